segment_digit_driver: RTL and testbench
=======================================

SEGMENT_DIGIT_DRIVER -- requirements
Module: segment_digit_driver

Interface
REQ-001 SHALL have port i_Clk, input, 1: sole clock; all state on rising edge.
REQ-002 SHALL have port i_Rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port i_Anodos, input, 4: one-hot digit strobe from ring counter (bit n = digit n).
REQ-004 SHALL have port i_Dato, input, 16: four hex nibbles; [3:0] = digit 0.
REQ-005 SHALL have port i_Dp, input, 4: decimal-point request per digit, active-high.
REQ-006 SHALL have port i_Valid, input, 1: i_Dato/i_Dp offered this cycle.
REQ-007 SHALL have port o_Ready, output, 1: shadow buffer free; transfer when i_Valid && o_Ready.
REQ-008 SHALL have port o_Anodos, output, 4: registered copy of i_Anodos, aligned with o_Segmentos.
REQ-009 SHALL have port o_Segmentos, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port o_Dp, output, 1: decimal point, active-low.

Function
REQ-011 SHALL hold three registers: shadow (16+4 bits), display (16+4 bits), pending flag.
REQ-012 SHALL drive o_Ready = !pending combinationally.
REQ-013 On i_Valid && o_Ready SHALL load shadow with i_Dato/i_Dp and set pending next cycle.
REQ-014 SHALL detect frame end as registered previous strobe == 4'b1000 and current i_Anodos != 4'b1000.
REQ-015 On frame end with pending = 1 SHALL copy shadow to display and clear pending in the same edge.
REQ-016 On a transfer in the same cycle as frame end with pending = 0, the new value SHALL go to shadow only and commit at the next frame end.
REQ-017 SHALL never change display mid-frame; a shown frame always comes from one committed value.
REQ-018 SHALL select nibble n and i_Dp bit n from display when i_Anodos bit n is the only set bit.
REQ-019 SHALL decode the nibble 0-F to standard hex 7-segment patterns (A,b,C,d,E,F for 10-15).
REQ-020 SHALL register o_Segmentos, o_Dp and o_Anodos together: one-cycle latency from i_Anodos, mutually aligned.
REQ-021 If i_Anodos is not one-hot (0000, multiple bits), next cycle SHALL output o_Anodos = 4'b0000, o_Segmentos = 7'b1111111, o_Dp = 1.
REQ-022 Without back-to-back commits, a value accepted mid-frame SHALL appear on the digits of the next full frame.

Reset
REQ-023 While i_Rst = 1: shadow = 0, display = 0, pending = 0, previous strobe = 4'b0000, o_Anodos = 4'b0000, o_Segmentos = 7'b1111111, o_Dp = 1, o_Ready = 1.
REQ-024 Reset asserted mid-frame or with pending = 1 SHALL discard shadow; no commit after release until a new transfer plus frame end.

Configuration
REQ-025 With macro LEADING_ZERO_BLANK_EN defined, digits 3..1 SHALL show blank (7'b1111111) when that nibble and all higher nibbles of display are zero; digit 0 never blanked; o_Dp unaffected.
REQ-026 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always show their decoded nibble.

Structure
REQ-027 Shared package seg_pkg SHALL hold segment constants (SEG_BLANK = 7'b1111111, 16-entry hex pattern table) and NUM_DIGITS = 4.
REQ-028 SHALL instantiate one sub-module hex_to_7seg (4-bit in, 7-bit active-low out, combinational).

Verification
REQ-029 Reset then strobes cycling 0001..1000: o_Segmentos = 7'b1000000 (digit "0") on every digit, o_Ready = 1.
REQ-030 Transfer 16'h1234, i_Dp = 4'b0100 mid-frame: current frame unchanged; next frame digit0 = "4" (7'b0011001), digit1 = "3", digit2 = "2" with o_Dp = 0, digit3 = "1".
REQ-031 Second i_Valid while pending: o_Ready = 0, value ignored; after frame-end commit o_Ready = 1 next cycle.
REQ-032 Transfer in exact frame-end cycle with pending = 0: shows one frame later than normal per REQ-016.
REQ-033 i_Anodos = 4'b0110 for one cycle: next cycle o_Anodos = 0000, o_Segmentos = 7'b1111111, o_Dp = 1.
REQ-034 LEADING_ZERO_BLANK_EN defined, display 16'h0070: digits 3,2 blank, digit1 = "7", digit0 = "0"; 16'h0000 shows only digit0 = "0".

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and types for the seven-segment digit driver.
//
// Contents:
//   NUM_DIGITS  number of multiplexed digits (4)
//   SEG_BLANK   active-low pattern with every segment off
//   SEG_TABLE   16-entry hex pattern table, bit order {g,f,e,d,c,b,a}, active-low
//   frame_t     one displayable value: four hex nibbles plus four decimal points
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index 0 is the rightmost entry. Letters 10..15 use the usual A,b,C,d,E,F
  // shapes so that b and d cannot be mistaken for 8 and 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] dato;
    logic [NUM_DIGITS-1:0]   dp;
  } frame_t;

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg -- combinational hex nibble to seven-segment pattern decoder.
//
// Ports:
//   i_Nibble  4-bit hex value 0..F
//   o_Seg     7-bit pattern {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Seg
);

  // A plain table lookup keeps the decoder and the package table as the single
  // source of truth for the glyph shapes.
  assign o_Seg = SEG_TABLE[i_Nibble];

endmodule

// File: rtl/segment_digit_driver.sv
// segment_digit_driver -- double-buffered, frame-synchronous driver for a
// four-digit multiplexed seven-segment display.
//
// A new value is accepted into a shadow buffer with a valid/ready handshake
// and is only moved into the display buffer at a frame boundary, so a single
// scan of the four digits always shows one coherent value.
//
// Ports:
//   i_Clk        clock, all state on the rising edge
//   i_Rst        asynchronous active-high reset
//   i_Anodos     one-hot digit strobe from the external ring counter
//   i_Dato       four hex nibbles, [3:0] is digit 0
//   i_Dp         decimal point request per digit, active-high
//   i_Valid      i_Dato/i_Dp offered this cycle
//   o_Ready      shadow buffer free; transfer happens on i_Valid && o_Ready
//   o_Anodos     registered strobe, aligned with o_Segmentos/o_Dp
//   o_Segmentos  segments {g,f,e,d,c,b,a}, active-low
//   o_Dp         decimal point, active-low
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits 3..1 are blanked while they and
//                          every higher nibble are zero; digit 0 always shows.
module segment_digit_driver
  import seg_pkg::*;
(
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [NUM_DIGITS-1:0]   i_Anodos,
  input  logic [4*NUM_DIGITS-1:0] i_Dato,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  output logic [NUM_DIGITS-1:0]   o_Anodos,
  output logic [6:0]              o_Segmentos,
  output logic                    o_Dp
);

  frame_t                shadow_q, shadow_d;
  frame_t                display_q, display_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] prevAnodos_q;
  logic [NUM_DIGITS-1:0] anodos_q, anodos_d;
  logic [6:0]            segmentos_q, segmentos_d;
  logic                  dp_q, dp_d;

  logic       transfer;
  logic       frameEnd;
  logic       commit;
  logic       strobeValid;
  logic [3:0] nibble;
  logic       dpBit;
  logic       blankDigit;
  logic [6:0] decoded;

  assign o_Ready  = !pending_q;
  assign transfer = i_Valid && !pending_q;

  // The last digit of a frame has just been left: the strobe was on digit 3
  // last cycle and has moved on. This edge is the only place display changes.
  assign frameEnd = (prevAnodos_q == 4'b1000) && (i_Anodos != 4'b1000);
  assign commit   = frameEnd && pending_q;

  // Buffer bookkeeping. A transfer needs pending clear and a commit needs it
  // set, so the two never collide; a transfer landing on a frame end with
  // nothing pending simply waits in shadow for the following frame end.
  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    if (transfer) begin
      shadow_d.dato = i_Dato;
      shadow_d.dp   = i_Dp;
      pending_d     = 1'b1;
    end
    if (commit) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Digit selection reads the display value that will hold after this edge,
  // so the first digit of a new frame already uses the freshly committed
  // value and the whole frame comes from one value. Any strobe that is not
  // one-hot produces a dark digit.
  always_comb begin
    strobeValid = 1'b1;
    nibble      = 4'h0;
    dpBit       = 1'b0;
    blankDigit  = 1'b0;
    case (i_Anodos)
      4'b0001: begin
        nibble = display_d.dato[3:0];
        dpBit  = display_d.dp[0];
      end
      4'b0010: begin
        nibble = display_d.dato[7:4];
        dpBit  = display_d.dp[1];
`ifdef LEADING_ZERO_BLANK_EN
        blankDigit = (display_d.dato[15:4] == 12'h000);
`endif
      end
      4'b0100: begin
        nibble = display_d.dato[11:8];
        dpBit  = display_d.dp[2];
`ifdef LEADING_ZERO_BLANK_EN
        blankDigit = (display_d.dato[15:8] == 8'h00);
`endif
      end
      4'b1000: begin
        nibble = display_d.dato[15:12];
        dpBit  = display_d.dp[3];
`ifdef LEADING_ZERO_BLANK_EN
        blankDigit = (display_d.dato[15:12] == 4'h0);
`endif
      end
      default: strobeValid = 1'b0;
    endcase
  end

  hex_to_7seg u_Hex (
    .i_Nibble (nibble),
    .o_Seg    (decoded)
  );

  // Next values for the three display outputs, which are registered together
  // so anode, segments and decimal point always line up.
  always_comb begin
    anodos_d    = '0;
    segmentos_d = SEG_BLANK;
    dp_d        = 1'b1;
    if (strobeValid) begin
      anodos_d    = i_Anodos;
      segmentos_d = blankDigit ? SEG_BLANK : decoded;
      dp_d        = !dpBit;
    end
  end

  // All state, cleared asynchronously. Reset discards any pending shadow value.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      prevAnodos_q <= '0;
      anodos_q     <= '0;
      segmentos_q  <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      prevAnodos_q <= i_Anodos;
      anodos_q     <= anodos_d;
      segmentos_q  <= segmentos_d;
      dp_q         <= dp_d;
    end
  end

  assign o_Anodos    = anodos_q;
  assign o_Segmentos = segmentos_q;
  assign o_Dp        = dp_q;

endmodule

// File: tb/tb_segment_digit_driver.sv
// tb_segment_digit_driver -- directed self-checking bench for
// segment_digit_driver. Expected glyphs come from a hand-written hex table.
module tb_segment_digit_driver;

  logic        i_Clk;
  logic        i_Rst;
  logic [3:0]  i_Anodos;
  logic [15:0] i_Dato;
  logic [3:0]  i_Dp;
  logic        i_Valid;
  logic        o_Ready;
  logic [3:0]  o_Anodos;
  logic [6:0]  o_Segmentos;
  logic        o_Dp;

  int compared   = 0;
  int mismatched = 0;

  segment_digit_driver dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Anodos    (i_Anodos),
    .i_Dato      (i_Dato),
    .i_Dp        (i_Dp),
    .i_Valid     (i_Valid),
    .o_Ready     (o_Ready),
    .o_Anodos    (o_Anodos),
    .o_Segmentos (o_Segmentos),
    .o_Dp        (o_Dp)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Expected active-low glyph for one digit of a displayed value.
  function automatic logic [6:0] expSeg(input logic [15:0] val, input int digit);
    logic [15:0] shifted;
    logic [3:0]  nib;
    shifted = val >> (4 * digit);
    nib     = shifted[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (digit > 0 && shifted == 16'h0000) return 7'b1111111;
`endif
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [3:0] anodos, input logic valid,
                               input logic [15:0] dato, input logic [3:0] dp);
    i_Anodos = anodos;
    i_Valid  = valid;
    i_Dato   = dato;
    i_Dp     = dp;
    @(posedge i_Clk);
    #1;
    i_Valid = 1'b0;
  endtask

  // Strobe digit n and check the registered outputs against the value shown.
  task automatic showDigit(input string tag, input int n, input logic [15:0] expVal,
                           input logic [3:0] expDp, input logic valid,
                           input logic [15:0] dato, input logic [3:0] dp);
    logic [3:0] strobe;
    logic       expDpOut;
    strobe   = 4'b0001 << n;
    expDpOut = ~expDp[n];
    applyStimulus(strobe, valid, dato, dp);
    checkOutput($sformatf("%s_an%0d", tag, n), {28'd0, o_Anodos}, {28'd0, strobe});
    checkOutput($sformatf("%s_seg%0d", tag, n), {25'd0, o_Segmentos},
                {25'd0, expSeg(expVal, n)});
    checkOutput($sformatf("%s_dp%0d", tag, n), {31'd0, o_Dp}, {31'd0, expDpOut});
  endtask

  task automatic runFrame(input string tag, input logic [15:0] expVal,
                          input logic [3:0] expDp);
    for (int n = 0; n < 4; n++) showDigit(tag, n, expVal, expDp, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic checkDark(input string tag);
    checkOutput({tag, "_an"}, {28'd0, o_Anodos}, 32'h0);
    checkOutput({tag, "_seg"}, {25'd0, o_Segmentos}, 32'h7F);
    checkOutput({tag, "_dp"}, {31'd0, o_Dp}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_Rst    = 1'b1;
    i_Anodos = 4'h0;
    i_Dato   = 16'h0;
    i_Dp     = 4'h0;
    i_Valid  = 1'b0;
    repeat (3) @(posedge i_Clk);
    #1;
    checkDark("reset");
    checkOutput("reset_ready", {31'd0, o_Ready}, 32'h1);
    i_Rst = 1'b0;

    // Two frames of zeros straight out of reset.
    runFrame("f0", 16'h0000, 4'h0);
    checkOutput("f0_ready", {31'd0, o_Ready}, 32'h1);
    runFrame("f1", 16'h0000, 4'h0);

    // Accept 1234 mid-frame; a second offer while pending is ignored.
    showDigit("f2", 0, 16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);
    checkOutput("f2_ready_before", {31'd0, o_Ready}, 32'h1);
    showDigit("f2", 1, 16'h0000, 4'h0, 1'b1, 16'h1234, 4'b0100);
    checkOutput("f2_ready_pending", {31'd0, o_Ready}, 32'h0);
    showDigit("f2", 2, 16'h0000, 4'h0, 1'b1, 16'hABCD, 4'b1111);
    checkOutput("f2_ready_still", {31'd0, o_Ready}, 32'h0);
    showDigit("f2", 3, 16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);

    // Next frame shows 1234 with the point on digit 2; ready returns.
    showDigit("f3", 0, 16'h1234, 4'b0100, 1'b0, 16'h0, 4'h0);
    checkOutput("f3_ready_commit", {31'd0, o_Ready}, 32'h1);
    for (int n = 1; n < 4; n++) showDigit("f3", n, 16'h1234, 4'b0100, 1'b0, 16'h0, 4'h0);

    // Transfer exactly on the frame-end cycle: waits a whole extra frame.
    checkOutput("f4_ready_before", {31'd0, o_Ready}, 32'h1);
    showDigit("f4", 0, 16'h1234, 4'b0100, 1'b1, 16'h5678, 4'b0001);
    checkOutput("f4_ready_pending", {31'd0, o_Ready}, 32'h0);
    for (int n = 1; n < 4; n++) showDigit("f4", n, 16'h1234, 4'b0100, 1'b0, 16'h0, 4'h0);
    runFrame("f5", 16'h5678, 4'b0001);
    checkOutput("f5_ready", {31'd0, o_Ready}, 32'h1);

    // Illegal strobes give a dark digit.
    applyStimulus(4'b0110, 1'b0, 16'h0, 4'h0);
    checkDark("multi");
    applyStimulus(4'b0000, 1'b0, 16'h0, 4'h0);
    checkDark("none");
    runFrame("f6", 16'h5678, 4'b0001);

    // Reset with a pending value discards it.
    showDigit("f7", 0, 16'h5678, 4'b0001, 1'b0, 16'h0, 4'h0);
    showDigit("f7", 1, 16'h5678, 4'b0001, 1'b1, 16'h9999, 4'b1111);
    checkOutput("f7_ready_pending", {31'd0, o_Ready}, 32'h0);
    i_Rst = 1'b1;
    #1;
    checkDark("async_rst");
    checkOutput("async_rst_ready", {31'd0, o_Ready}, 32'h1);
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    runFrame("r0", 16'h0000, 4'h0);
    runFrame("r1", 16'h0000, 4'h0);

    // Leading-zero values (blanked only when the option is built in).
    showDigit("lz0", 0, 16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);
    showDigit("lz0", 1, 16'h0000, 4'h0, 1'b1, 16'h0070, 4'h0);
    showDigit("lz0", 2, 16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);
    showDigit("lz0", 3, 16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);
    showDigit("lz70", 0, 16'h0070, 4'h0, 1'b0, 16'h0, 4'h0);
    showDigit("lz70", 1, 16'h0070, 4'h0, 1'b1, 16'h0000, 4'h0);
    showDigit("lz70", 2, 16'h0070, 4'h0, 1'b0, 16'h0, 4'h0);
    showDigit("lz70", 3, 16'h0070, 4'h0, 1'b0, 16'h0, 4'h0);
    runFrame("lz00", 16'h0000, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
